// File: rtl/ibex_rf_write_sched.sv
// ============================================================================
// ibex_rf_write_sched : register-file write-port scheduler with reset clear
// Rev 1.0
// ============================================================================
`default_nettype none

module ibex_rf_write_sched #(
  parameter int unsigned            RV32E          = 0,
  parameter int unsigned            DATA_WIDTH     = 32,
  parameter logic [DATA_WIDTH-1:0]  WORD_ZERO_VAL  = '0,
  parameter bit                     CLEAR_ON_RESET = 1'b1,
  parameter int unsigned            STARVE_LIMIT   = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  ex_we_i,
  input  logic [4:0]            ex_waddr_i,
  input  logic [DATA_WIDTH-1:0] ex_wdata_i,
  input  logic                  lsu_valid_i,
  output logic                  lsu_ready_o,
  input  logic [4:0]            lsu_waddr_i,
  input  logic [DATA_WIDTH-1:0] lsu_wdata_i,
  output logic                  init_done_o,
  output logic                  lsu_pend_o,
  output logic [4:0]            lsu_pend_addr_o,
  output logic                  ex_stall_req_o,
  output logic                  rf_we_o,
  output logic [4:0]            rf_waddr_o,
  output logic [DATA_WIDTH-1:0] rf_wdata_o
);

  localparam int unsigned      c_NUM_REGS = (RV32E != 0) ? 16 : 32;
  localparam logic [4:0]       c_LAST_REG = 5'(c_NUM_REGS - 1);
  localparam int unsigned      c_AGE_W    = $clog2(STARVE_LIMIT + 2);
  localparam logic [c_AGE_W-1:0] c_STARVE = c_AGE_W'(STARVE_LIMIT);
  localparam logic [c_AGE_W-1:0] c_AGE_MAX = '1;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [4:0]            r_cnt, w_cnt_nxt;
  logic                  r_buf_valid, w_buf_valid_nxt;
  logic [4:0]            r_buf_addr, w_buf_addr_nxt;
  logic [DATA_WIDTH-1:0] r_buf_data, w_buf_data_nxt;
  logic [c_AGE_W-1:0]    r_age, w_age_nxt;
  logic                  r_we, w_we_nxt;
  logic [4:0]            r_waddr, w_waddr_nxt;
  logic [DATA_WIDTH-1:0] r_wdata, w_wdata_nxt;
  logic                  r_ready, w_ready_nxt;
  logic                  r_stall, w_stall_nxt;
  logic                  r_init_done, w_init_done_nxt;
  logic                  w_ex_ok, w_lsu_acc, w_lsu_ok;

  function automatic logic f_legal(input logic [4:0] a);
    return (a != 5'd0) && ((RV32E == 0) || !a[4]);
  endfunction

  assign w_ex_ok   = ex_we_i && f_legal(ex_waddr_i);
  assign w_lsu_acc = lsu_valid_i && r_ready;
  assign w_lsu_ok  = f_legal(lsu_waddr_i);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
      r_cnt       <= 5'd1;
      r_buf_valid <= 1'b0;
      r_buf_addr  <= 5'd0;
      r_buf_data  <= '0;
      r_age       <= '0;
      r_we        <= 1'b0;
      r_waddr     <= 5'd0;
      r_wdata     <= WORD_ZERO_VAL;
      r_ready     <= 1'b0;
      r_stall     <= 1'b0;
      r_init_done <= !CLEAR_ON_RESET;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_buf_valid <= w_buf_valid_nxt;
      r_buf_addr  <= w_buf_addr_nxt;
      r_buf_data  <= w_buf_data_nxt;
      r_age       <= w_age_nxt;
      r_we        <= w_we_nxt;
      r_waddr     <= w_waddr_nxt;
      r_wdata     <= w_wdata_nxt;
      r_ready     <= w_ready_nxt;
      r_stall     <= w_stall_nxt;
      r_init_done <= w_init_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_buf_valid_nxt = r_buf_valid;
    w_buf_addr_nxt  = r_buf_addr;
    w_buf_data_nxt  = r_buf_data;
    w_we_nxt        = 1'b0;
    w_waddr_nxt     = r_waddr;
    w_wdata_nxt     = r_wdata;

    case (r_state)
      ST_CLEAR: begin
        w_we_nxt    = 1'b1;
        w_waddr_nxt = r_cnt;
        w_wdata_nxt = WORD_ZERO_VAL;
        w_cnt_nxt   = r_cnt + 5'd1;
        if (r_cnt == c_LAST_REG) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (w_ex_ok) begin
          w_we_nxt    = 1'b1;
          w_waddr_nxt = ex_waddr_i;
          w_wdata_nxt = ex_wdata_i;
          // The EX result is younger than a buffered load to the same register.
          if (r_buf_valid && (r_buf_addr == ex_waddr_i)) begin
            w_buf_valid_nxt = 1'b0;
          end
          if (w_lsu_acc && w_lsu_ok) begin
            w_buf_valid_nxt = 1'b1;
            w_buf_addr_nxt  = lsu_waddr_i;
            w_buf_data_nxt  = lsu_wdata_i;
          end
        end else if (r_buf_valid) begin
          w_we_nxt        = 1'b1;
          w_waddr_nxt     = r_buf_addr;
          w_wdata_nxt     = r_buf_data;
          w_buf_valid_nxt = 1'b0;
        end else if (w_lsu_acc && w_lsu_ok) begin
          w_we_nxt    = 1'b1;
          w_waddr_nxt = lsu_waddr_i;
          w_wdata_nxt = lsu_wdata_i;
        end
      end
      default: w_state_nxt = ST_RUN;
    endcase

    if (w_buf_valid_nxt && r_buf_valid) begin
      w_age_nxt = (r_age == c_AGE_MAX) ? r_age : r_age + c_AGE_W'(1);
    end else begin
      w_age_nxt = '0;
    end

    w_stall_nxt     = w_buf_valid_nxt && (w_age_nxt >= c_STARVE);
    w_ready_nxt     = (w_state_nxt == ST_RUN) && !w_buf_valid_nxt;
    w_init_done_nxt = r_init_done || (r_state == ST_RUN);
  end

  assign lsu_ready_o     = r_ready;
  assign init_done_o     = r_init_done;
  assign lsu_pend_o      = r_buf_valid;
  assign lsu_pend_addr_o = r_buf_valid ? r_buf_addr : 5'd0;
  assign ex_stall_req_o  = r_stall;
  assign rf_we_o         = r_we;
  assign rf_waddr_o      = r_waddr;
  assign rf_wdata_o      = r_wdata;

endmodule

`default_nettype wire

// File: tb/tb_ibex_rf_write_sched.sv
// ============================================================================
// tb_ibex_rf_write_sched : random + directed bench for two scheduler configs
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_ibex_rf_write_sched;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        ex_we_i;
  logic [4:0]  ex_waddr_i;
  logic [31:0] ex_wdata_i;
  logic        lsu_valid_i;
  logic [4:0]  lsu_waddr_i;
  logic [31:0] lsu_wdata_i;

  logic [1:0]  rdy, done, pend, stall, we;
  logic [4:0]  paddr [2];
  logic [4:0]  waddr [2];
  logic [31:0] wdata [2];

  always #5 clk_i = ~clk_i;

  ibex_rf_write_sched #(
    .RV32E(0), .DATA_WIDTH(32), .WORD_ZERO_VAL(32'h0), .CLEAR_ON_RESET(1'b1), .STARVE_LIMIT(2)
  ) u_dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .ex_we_i(ex_we_i), .ex_waddr_i(ex_waddr_i), .ex_wdata_i(ex_wdata_i),
    .lsu_valid_i(lsu_valid_i), .lsu_ready_o(rdy[0]), .lsu_waddr_i(lsu_waddr_i), .lsu_wdata_i(lsu_wdata_i),
    .init_done_o(done[0]), .lsu_pend_o(pend[0]), .lsu_pend_addr_o(paddr[0]), .ex_stall_req_o(stall[0]),
    .rf_we_o(we[0]), .rf_waddr_o(waddr[0]), .rf_wdata_o(wdata[0])
  );

  ibex_rf_write_sched #(
    .RV32E(1), .DATA_WIDTH(32), .WORD_ZERO_VAL(32'hA5A5_0000), .CLEAR_ON_RESET(1'b1), .STARVE_LIMIT(3)
  ) u_dut_e (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .ex_we_i(ex_we_i), .ex_waddr_i(ex_waddr_i), .ex_wdata_i(ex_wdata_i),
    .lsu_valid_i(lsu_valid_i), .lsu_ready_o(rdy[1]), .lsu_waddr_i(lsu_waddr_i), .lsu_wdata_i(lsu_wdata_i),
    .init_done_o(done[1]), .lsu_pend_o(pend[1]), .lsu_pend_addr_o(paddr[1]), .ex_stall_req_o(stall[1]),
    .rf_we_o(we[1]), .rf_waddr_o(waddr[1]), .rf_wdata_o(wdata[1])
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Reference model state, one slot per configuration.
  bit          m_clearing [2];
  int          m_clr_next [2];
  bit          m_done     [2];
  bit          m_done_soon[2];
  bit          m_have     [2];
  logic [4:0]  m_paddr    [2];
  logic [31:0] m_pdata    [2];
  int          m_birth    [2];
  bit          e_we       [2];
  logic [4:0]  e_waddr    [2];
  logic [31:0] e_wdata    [2];

  function automatic int nregs(int k);
    return (k == 0) ? 32 : 16;
  endfunction

  function automatic logic [31:0] zval(int k);
    return (k == 0) ? 32'h0 : 32'hA5A5_0000;
  endfunction

  function automatic int limit(int k);
    return (k == 0) ? 2 : 3;
  endfunction

  function automatic bit legal(int k, logic [4:0] a);
    return (a != 5'd0) && ((k == 0) || (int'(a) < 16));
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  task automatic m_reset();
    for (int k = 0; k < 2; k++) begin
      m_clearing[k]  = 1'b1;
      m_clr_next[k]  = 1;
      m_done[k]      = 1'b0;
      m_done_soon[k] = 1'b0;
      m_have[k]      = 1'b0;
      m_paddr[k]     = 5'd0;
      m_pdata[k]     = 32'h0;
      m_birth[k]     = 0;
      e_we[k]        = 1'b0;
      e_waddr[k]     = 5'd0;
      e_wdata[k]     = zval(k);
    end
  endtask

  task automatic m_step(input int k);
    bit acc;
    acc = lsu_valid_i && !m_clearing[k] && !m_have[k];
    e_we[k] = 1'b0;
    if (m_done_soon[k]) m_done[k] = 1'b1;
    if (m_clearing[k]) begin
      e_we[k]    = 1'b1;
      e_waddr[k] = 5'(m_clr_next[k]);
      e_wdata[k] = zval(k);
      if (m_clr_next[k] == nregs(k) - 1) begin
        m_clearing[k]  = 1'b0;
        m_done_soon[k] = 1'b1;
      end
      m_clr_next[k]++;
    end else if (ex_we_i && legal(k, ex_waddr_i)) begin
      e_we[k]    = 1'b1;
      e_waddr[k] = ex_waddr_i;
      e_wdata[k] = ex_wdata_i;
      if (m_have[k] && m_paddr[k] == ex_waddr_i) m_have[k] = 1'b0;
      if (acc && legal(k, lsu_waddr_i)) begin
        m_have[k]  = 1'b1;
        m_paddr[k] = lsu_waddr_i;
        m_pdata[k] = lsu_wdata_i;
        m_birth[k] = cyc;
      end
    end else if (m_have[k]) begin
      e_we[k]    = 1'b1;
      e_waddr[k] = m_paddr[k];
      e_wdata[k] = m_pdata[k];
      m_have[k]  = 1'b0;
    end else if (acc && legal(k, lsu_waddr_i)) begin
      e_we[k]    = 1'b1;
      e_waddr[k] = lsu_waddr_i;
      e_wdata[k] = lsu_wdata_i;
    end
  endtask

  task automatic check_all(input bit in_reset);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("we%0d", k), 32'(we[k]), 32'(e_we[k]));
      if (e_we[k] || in_reset) begin
        chk($sformatf("waddr%0d", k), 32'(waddr[k]), 32'(e_waddr[k]));
        chk($sformatf("wdata%0d", k), wdata[k], e_wdata[k]);
      end
      chk($sformatf("ready%0d", k), 32'(rdy[k]), 32'(!m_clearing[k] && !m_have[k] && !in_reset));
      chk($sformatf("pend%0d", k), 32'(pend[k]), 32'(m_have[k]));
      chk($sformatf("paddr%0d", k), 32'(paddr[k]), m_have[k] ? 32'(m_paddr[k]) : 32'h0);
      chk($sformatf("stall%0d", k), 32'(stall[k]),
          32'(m_have[k] && ((cyc - m_birth[k]) >= limit(k))));
      chk($sformatf("done%0d", k), 32'(done[k]), 32'(m_done[k]));
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    cyc++;
    m_step(0);
    m_step(1);
    #1;
    check_all(1'b0);
    @(negedge clk_i);
  endtask

  task automatic drv(input logic ew, input logic [4:0] ea, input logic [31:0] ed,
                     input logic lv, input logic [4:0] la, input logic [31:0] ld);
    ex_we_i     = ew;
    ex_waddr_i  = ea;
    ex_wdata_i  = ed;
    lsu_valid_i = lv;
    lsu_waddr_i = la;
    lsu_wdata_i = ld;
  endtask

  task automatic idle();
    drv(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
  endtask

  function automatic logic [4:0] pick();
    case ($urandom_range(0, 4))
      0:       return 5'd0;
      1:       return 5'd3;
      2:       return 5'd9;
      3:       return 5'd17;
      default: return 5'($urandom_range(0, 31));
    endcase
  endfunction

  initial begin
    rst_ni = 1'b0;
    idle();
    m_reset();
    #12;
    check_all(1'b1);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Partial clear, then reset in the middle of it.
    for (int i = 0; i < 7; i++) tick();
    rst_ni = 1'b0;
    #1;
    m_reset();
    check_all(1'b1);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Full clear sequence for both configurations.
    for (int i = 0; i < 34; i++) tick();

    // EX only, then lone load bypass.
    drv(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0); tick();
    idle(); tick();
    drv(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h1234); tick();
    idle(); tick();

    // Load accepted alongside an EX write goes through the buffer.
    drv(1'b1, 5'd3, 32'hA, 1'b1, 5'd9, 32'h1234); tick();
    idle(); tick();
    tick();

    // Buffered load killed by a younger EX write to the same register.
    drv(1'b1, 5'd3, 32'hA, 1'b1, 5'd9, 32'h1234); tick();
    drv(1'b1, 5'd9, 32'h55, 1'b0, 5'd0, 32'h0); tick();
    idle(); tick();
    tick();

    // Starvation under continuous EX traffic.
    drv(1'b1, 5'd3, 32'hA, 1'b1, 5'd9, 32'h1234); tick();
    for (int i = 0; i < 5; i++) begin
      drv(1'b1, 5'd4, 32'hB0 + 32'(i), 1'b0, 5'd0, 32'h0); tick();
    end
    idle(); tick();
    tick();

    // x0 and out-of-range destinations.
    drv(1'b1, 5'd0, 32'hFF, 1'b1, 5'd0, 32'hEE); tick();
    drv(1'b1, 5'd20, 32'h20, 1'b1, 5'd21, 32'h21); tick();
    idle(); tick();
    tick();

    // Randomised traffic.
    for (int i = 0; i < 3000; i++) begin
      drv(1'($urandom_range(0, 1)), pick(), $urandom,
          1'($urandom_range(0, 2) != 0), pick(), $urandom);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ibex_rf_write_sched.md
Name: ibex_rf_write_sched

Overview:
Write-port scheduler in front of the single-write-port integer register file. After reset it runs a clear sequence that walks every architectural register and writes WordZeroVal. In normal operation it merges two writeback sources onto one registered write port: the EX writeback, which has priority and never backpressures, and the LSU load writeback, which is handshaked and buffered. It also exports pending-load hazard info to the ID stage and a stall request when a buffered load is starved.

Parameters:
RV32E, 0, 1 = 16 registers (x0..x15), 0 = 32 registers; NumRegs derived as 16 or 32
DataWidth, 32, register width
WordZeroVal, '0, value written during clear and driven on rf_wdata_o at reset
ClearOnReset, 1, 1 = run clear sequence after reset; 0 = go straight to RUN
StarveLimit, 2, cycles a buffered load may wait before ex_stall_req_o asserts (>=1)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
ex_we_i  in  1  EX writeback valid
ex_waddr_i  in  5  EX destination register
ex_wdata_i  in  DataWidth  EX write data
lsu_valid_i  in  1  load writeback valid
lsu_ready_o  out  1  load writeback accepted when valid&ready
lsu_waddr_i  in  5  load destination register
lsu_wdata_i  in  DataWidth  load data
init_done_o  out  1  clear sequence complete; core may issue
lsu_pend_o  out  1  load held in buffer
lsu_pend_addr_o  out  5  destination of buffered load (0 when none)
ex_stall_req_o  out  1  request ID/EX to suppress ex_we_i next cycle
rf_we_o  out  1  register-file write enable (registered)
rf_waddr_o  out  5  register-file write address (registered)
rf_wdata_o  out  DataWidth  register-file write data (registered)

Behaviour:
- Reset values:
  - rf_we_o=0, rf_waddr_o=0, rf_wdata_o=WordZeroVal.
  - lsu_ready_o=0, lsu_pend_o=0, lsu_pend_addr_o=0, ex_stall_req_o=0.
  - init_done_o=!ClearOnReset.
  - State is CLEAR if ClearOnReset, else RUN. Clear counter=1, buffer empty, age=0.
- Reset asserted mid-operation: everything returns to reset values immediately; the clear sequence restarts from x1.
- CLEAR:
  - Each cycle the output register loads we=1, waddr=counter, wdata=WordZeroVal; counter increments.
  - After the cycle that loads counter=NumRegs-1, go to RUN. rf_we_o is high for exactly NumRegs-1 consecutive cycles (x1..x31, or x1..x15 when RV32E).
  - init_done_o rises the cycle after the final clear write is on rf_*.
  - lsu_ready_o=0. ex_we_i is ignored; upstream holds issue until init_done_o.
- RUN, lsu_ready_o = !buf_valid (registered state, not combinational on inputs).
- RUN write selection, priority high to low, result registered, latency 1 cycle:
  1. ex_we_i with a legal non-zero address: output loads the EX write.
  2. buf_valid: output loads the buffered load; buffer clears.
  3. lsu_valid_i&&lsu_ready_o with no EX write: load bypasses the buffer straight to the output register (1-cycle latency).
  4. Otherwise rf_we_o=0 next cycle.
- Load accepted in the same cycle as an EX write: captured into the buffer; earliest rf write is 2 cycles after acceptance.
- Address rules:
  - Address 0 is never written. EX writes to x0 are dropped and do not count as a port use.
  - LSU writes to x0 are accepted (handshake completes) and discarded without buffering.
  - When RV32E=1, addresses >=16 are dropped the same way.
- Same-address collision: if ex_we_i targets buf_waddr while buf_valid, the EX write wins and the buffer entry is killed (the EX result is younger). The killed entry is never written.
- Starvation:
  - age increments each cycle buf_valid remains set; it resets to 0 when the buffer empties.
  - ex_stall_req_o = buf_valid && age>=StarveLimit (registered).
  - ID must deassert ex_we_i the following cycle. If ex_we_i persists, priority is unchanged and no data is lost; the buffer keeps waiting.
- lsu_pend_o = buf_valid; lsu_pend_addr_o = buf_waddr when valid, else 0. ID uses these for the RAW stall.
- Width: rf_wdata_o is passed through unmodified; no arithmetic on data.

Test Plan:
- Reset release, ClearOnReset=1, RV32E=0 -> rf_we_o high 31 cycles with waddr 1..31 and wdata WordZeroVal; init_done_o=1 on the next cycle. Repeat with RV32E=1 -> 15 cycles, addresses 1..15.
- Pull rst_ni low at clear address 7, then release -> clear restarts at x1; full 31 writes occur.
- RUN: ex_we_i only, x5=0xDEADBEEF -> rf_we_o/waddr=5/wdata=0xDEADBEEF one cycle later. Lone load x9=0x1234 -> bypass, written 1 cycle later, lsu_pend_o stays 0.
- Load x9=0x1234 accepted together with EX x3=0xA -> x3 written at N+1, lsu_pend_o=1 with addr 9, lsu_ready_o=0; x9 written at N+2 when ex_we_i is low.
- Buffered load x9, then EX writes x9=0x55 -> only 0x55 is written to x9; buffer cleared; lsu_ready_o returns to 1.
- Buffered load with continuous ex_we_i, StarveLimit=2 -> ex_stall_req_o asserts after 2 cycles of waiting. Drop ex_we_i -> load written next cycle; stall request clears. EX and LSU writes to x0 -> no rf_we_o.
